// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding an 8N1 UART transmitter at a fixed baud rate.
// Producer is backpressured through o_wready when the FIFO is full.
module uart_tx_fifo #(
    parameter int unsigned CLK_HZ = 50000000,
    parameter int unsigned BAUD   = 115200,
    parameter int unsigned DEPTH  = 16
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic [7:0]                 i_wdata,
    input  logic                       i_wvalid,
    output logic                       o_wready,
    output logic                       o_tx,
    output logic                       o_busy,
    output logic [$clog2(DEPTH):0]     o_level
);

    localparam int unsigned DIV = CLK_HZ / BAUD;
    localparam int unsigned AW  = $clog2(DEPTH);
    localparam int unsigned PW  = AW + 1;
    localparam int unsigned CW  = (DIV > 1) ? $clog2(DIV) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t          state, state_d;
    logic [CW-1:0]   cnt, cnt_d;
    logic [2:0]      bit_idx, bit_idx_d;
    logic [7:0]      sh, sh_d;
    logic            tx_d;

    logic [7:0]      mem [DEPTH];
    logic [PW-1:0]   wr_ptr, rd_ptr, wr_d, rd_d;
    logic [PW-1:0]   level_d;
    logic            push, pop, empty, full_d;
    logic            busy_d;

    // Ready is a registered flag, so accepting a byte never depends on this cycle's pop.
    assign push  = i_wvalid & o_wready;
    assign empty = (wr_ptr == rd_ptr);

    always_ff @(posedge i_clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= i_wdata;
        end
    end

    // Frame sequencer: next state, shifter, baud/bit counters and line value.
    always_comb begin
        state_d   = state;
        cnt_d     = cnt;
        bit_idx_d = bit_idx;
        sh_d      = sh;
        pop       = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    sh_d    = mem[rd_ptr[AW-1:0]];
                    cnt_d   = '0;
                    state_d = START;
                end
            end
            START: begin
                if (cnt == CW'(DIV - 1)) begin
                    cnt_d     = '0;
                    bit_idx_d = '0;
                    state_d   = DATA;
                end else begin
                    cnt_d = cnt + CW'(1);
                end
            end
            DATA: begin
                if (cnt == CW'(DIV - 1)) begin
                    cnt_d = '0;
                    sh_d  = {1'b0, sh[7:1]};
                    if (bit_idx == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        bit_idx_d = bit_idx + 3'd1;
                    end
                end else begin
                    cnt_d = cnt + CW'(1);
                end
            end
            STOP: begin
                if (cnt == CW'(DIV - 1)) begin
                    cnt_d = '0;
                    if (!empty) begin
                        pop     = 1'b1;
                        sh_d    = mem[rd_ptr[AW-1:0]];
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = sh_d[0];
            default: tx_d = 1'b1;
        endcase
    end

    // Next pointers drive the registered full/level/busy flags.
    always_comb begin
        wr_d    = wr_ptr + PW'(push);
        rd_d    = rd_ptr + PW'(pop);
        full_d  = (wr_d[AW] != rd_d[AW]) && (wr_d[AW-1:0] == rd_d[AW-1:0]);
        level_d = wr_d - rd_d;
        busy_d  = (state_d != IDLE) || (level_d != '0);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state    <= IDLE;
            cnt      <= '0;
            bit_idx  <= '0;
            sh       <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            o_tx     <= 1'b1;
            o_wready <= 1'b1;
            o_busy   <= 1'b0;
            o_level  <= '0;
        end else begin
            state    <= state_d;
            cnt      <= cnt_d;
            bit_idx  <= bit_idx_d;
            sh       <= sh_d;
            wr_ptr   <= wr_d;
            rd_ptr   <= rd_d;
            o_tx     <= tx_d;
            o_wready <= !full_d;
            o_busy   <= busy_d;
            o_level  <= level_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Randomized bench for uart_tx_fifo against a queue-and-frame-timer reference model.
module tb_uart_tx_fifo;

    localparam int unsigned CLK_HZ = 400;
    localparam int unsigned BAUD   = 100;
    localparam int unsigned DIV    = CLK_HZ / BAUD;
    localparam int unsigned DEPTH  = 4;
    localparam int unsigned PW     = $clog2(DEPTH) + 1;

    logic          i_clk;
    logic          i_rst;
    logic [7:0]    i_wdata;
    logic          i_wvalid;
    logic          o_wready;
    logic          o_tx;
    logic          o_busy;
    logic [PW-1:0] o_level;

    int errors = 0;
    int checks = 0;

    uart_tx_fifo #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .DEPTH(DEPTH)) dut (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_wdata  (i_wdata),
        .i_wvalid (i_wvalid),
        .o_wready (o_wready),
        .o_tx     (o_tx),
        .o_busy   (o_busy),
        .o_level  (o_level)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Reference: FIFO contents as a queue, current frame as byte + elapsed cycles.
    logic [7:0] q[$];
    bit         in_frame;
    logic [7:0] fbyte;
    int         ft;
    bit         last_acc;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        q.delete();
        in_frame = 1'b0;
        fbyte    = '0;
        ft       = 0;
    endfunction

    function automatic bit model_edge(input bit vld, input logic [7:0] d);
        bit ready;
        ready = (q.size() < DEPTH);
        if (!in_frame) begin
            if (q.size() > 0) begin
                fbyte    = q.pop_front();
                in_frame = 1'b1;
                ft       = 0;
            end
        end else if (ft == 10 * DIV - 1) begin
            if (q.size() > 0) begin
                fbyte = q.pop_front();
                ft    = 0;
            end else begin
                in_frame = 1'b0;
            end
        end else begin
            ft++;
        end
        if (vld && ready) q.push_back(d);
        return vld && ready;
    endfunction

    function automatic logic exp_tx();
        int b;
        if (!in_frame) return 1'b1;
        b = ft / DIV;
        if (b == 0) return 1'b0;
        if (b == 9) return 1'b1;
        return fbyte[b-1];
    endfunction

    task automatic check_outputs(input string ctx);
        check({ctx, ".tx"},    32'(o_tx),     32'(exp_tx()));
        check({ctx, ".level"}, 32'(o_level),  32'(q.size()));
        check({ctx, ".wready"},32'(o_wready), 32'(q.size() < DEPTH));
        check({ctx, ".busy"},  32'(o_busy),   32'(in_frame || q.size() != 0));
    endtask

    // One clock: capture pre-edge inputs, advance model, compare 1 time unit later.
    task automatic tick(input string ctx);
        bit vld;
        logic [7:0] dat;
        vld = i_wvalid;
        dat = i_wdata;
        @(posedge i_clk);
        last_acc = model_edge(vld, dat);
        #1;
        check_outputs(ctx);
    endtask

    task automatic run(input int n, input string ctx);
        i_wvalid = 1'b0;
        for (int i = 0; i < n; i++) tick(ctx);
    endtask

    task automatic push_byte(input logic [7:0] b, input string ctx);
        int budget;
        i_wdata  = b;
        i_wvalid = 1'b1;
        budget   = 0;
        last_acc = 1'b0;
        while (!last_acc && budget < 200) begin
            tick(ctx);
            budget++;
        end
        if (!last_acc) check({ctx, ".push_timeout"}, 32'd0, 32'd1);
        i_wvalid = 1'b0;
    endtask

    task automatic random_traffic(input int n, input int pct, input string ctx);
        bit holding;
        holding = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (!holding) begin
                i_wvalid = ($urandom_range(99) < pct);
                i_wdata  = 8'($urandom);
            end
            tick(ctx);
            holding = i_wvalid && !last_acc;
        end
        i_wvalid = 1'b0;
    endtask

    initial begin
        int budget;
        int lvl_ones;
        logic [7:0] seq_byte;

        i_rst    = 1'b1;
        i_wvalid = 1'b0;
        i_wdata  = '0;
        model_reset();
        #1;
        check_outputs("reset");
        repeat (2) @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        run(3, "idle");

        // Single byte: level must read 1 for exactly one cycle.
        i_wdata  = 8'h55;
        i_wvalid = 1'b1;
        tick("single");
        i_wvalid = 1'b0;
        lvl_ones = (o_level == 1) ? 1 : 0;
        for (int i = 0; i < 10 * DIV + 4; i++) begin
            tick("single");
            if (o_level == 1) lvl_ones++;
        end
        check("single.level_one_cycles", 32'(lvl_ones), 32'd1);

        // Backpressure with a held 6th byte.
        for (int b = 1; b <= 6; b++) begin
            seq_byte = 8'(b);
            push_byte(seq_byte, "backpressure");
        end
        run(7 * 10 * DIV, "bp_drain");

        // Back-to-back frames.
        push_byte(8'hA5, "b2b");
        push_byte(8'h3C, "b2b");
        run(2 * 10 * DIV + 4, "b2b_drain");

        // Reset in the middle of data bit 3 of 0xFF with two bytes queued.
        push_byte(8'hFF, "rst_mid");
        push_byte(8'h11, "rst_mid");
        push_byte(8'h22, "rst_mid");
        budget = 0;
        while (!(in_frame && fbyte == 8'hFF && ft == 4 * DIV + 1) && budget < 100) begin
            tick("rst_mid");
            budget++;
        end
        check("rst_mid.reached_bit3", 32'(in_frame && ft == 4 * DIV + 1), 32'd1);
        check("rst_mid.queued", 32'(o_level), 32'd2);
        #2;
        i_rst = 1'b1;
        model_reset();
        #1;
        check_outputs("rst_async");
        repeat (2) @(posedge i_clk);
        #1;
        check_outputs("rst_hold");
        i_rst = 1'b0;
        run(2, "post_rst");
        push_byte(8'h00, "zero");
        run(10 * DIV + 4, "zero_drain");

        // Wrap-around: 11 bytes with random gaps.
        for (int b = 0; b < 11; b++) begin
            if ($urandom_range(1) == 1) run($urandom_range(3), "wrap_gap");
            seq_byte = 8'(8'h10 + b);
            push_byte(seq_byte, "wrap");
        end
        run(12 * 10 * DIV, "wrap_drain");

        // Random traffic at two densities.
        random_traffic(600, 15, "rand_sparse");
        random_traffic(600, 80, "rand_dense");
        run(6 * 10 * DIV, "final_drain");
        check("final.idle_busy", 32'(o_busy), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
